bit_unpack_stream: RTL and testbench
====================================

# bit_unpack_stream

Streaming ML-DSA coefficient unpacker. Accepts a packed polynomial (256 coefficients of c bits each, 32·c bytes) over a valid/ready byte-stream bus and emits one coefficient per handshake. It supports both SimpleBitUnpack (zero-extended z) and BitUnpack (b − z, signed) with runtime-selectable width c. It sits between the key/signature byte-stream decoder and the NTT/polynomial buffer, replacing the fixed, fully parallel unpack stage.

## Interface
- IN_W, 32, input bus width in bits; one of 8, 16, 32, 64.
- MAX_C, 20, largest supported coefficient bit width c.
- COEF_W, 24, output coefficient width in bits (two's complement in signed mode).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a polynomial; sampled only in IDLE.
- cfg_c  in  5  coefficient bit width c; latched on accepted start.
- cfg_b  in  COEF_W  bound b; latched on accepted start.
- cfg_signed  in  1  0 = SimpleBitUnpack, 1 = BitUnpack; latched on accepted start.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- in_data  in  IN_W  packed bytes; byte 0 in [7:0]; bit 0 of byte 0 is the first stream bit.
- out_valid  out  1  coefficient valid.
- out_ready  in  1  downstream accepts.
- out_data  out  COEF_W  coefficient.
- out_idx  out  8  coefficient index 0..255.
- out_last  out  1  high with index 255.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse after the index-255 handshake.
- cfg_err  out  1  sticky; set when start carries cfg_c == 0 or cfg_c > MAX_C.
- range_err  out  1  sticky range flag (see Configuration).

## Operation
- States: IDLE, RUN. IDLE→RUN on start with a valid cfg_c. RUN→IDLE on the out handshake of index 255, with done pulsing in the following cycle. start is ignored in RUN.
- An invalid cfg_c sets cfg_err and the block stays in IDLE. An accepted start clears cfg_err and range_err.
- Bit buffer is BUF_W = MAX_C + IN_W bits, with fill counter fill. An accepted word is appended at bit position fill (LSB-first stream).
- in_ready = RUN && words_left != 0 && fill ≤ BUF_W − IN_W. words_left loads 256·c/IN_W on start; the division is always exact.
- Extraction rule: when RUN && fill ≥ c && (!out_valid || out_ready), z = buf[c−1:0], the buffer shifts right by c, and fill −= c.
- Mapping: unsigned gives out_data = zero-extend(z). Signed gives out_data = cfg_b − z computed modulo 2^COEF_W.
- Append and extract may occur on the same edge: fill_next = fill + IN_W·acc − c·ext.
- After index 255 the buffer is empty and words_left is 0. No residual bits exist.
- Reset values: all outputs 0; state IDLE; fill, words_left, index and buffer cleared.
- A reset mid-run aborts immediately. No done pulse is produced, and the partial polynomial is discarded.

## Timing
- An input handshake in cycle t makes its first coefficient visible with out_valid high in cycle t+2, provided fill ≥ c.
- Sustained throughput is 1 coefficient/cycle whenever IN_W ≥ c. Otherwise it is bounded by the input rate, averaging IN_W/c coefficients per word.
- out_data, out_idx and out_last hold stable while out_valid && !out_ready.
- done is high in the cycle after the final out handshake. busy falls in that same cycle.

## Configuration
- Macro: BIT_UNPACK_RANGE_CHECK_EN.
- Defined: range_err is set when z > cfg_b (unsigned mode) or z > 2·cfg_b (signed mode). The check is evaluated at extraction, and the offending coefficient is still emitted.
- Undefined: the range_err port is present and tied to 0, and no comparator is synthesised.

## Test plan
- Unsigned, IN_W=32, c=10: stream 80 words encoding z_i = i·3 mod 1024 → 256 outputs equal to i·3 mod 1024, out_last only at idx 255, done one cycle later, words_left 0.
- Signed, c=3, b=2: coefficients z = 0,1,2,3,4 repeating → out_data = 2,1,0,−1 (0xFFFFFF), −2 (0xFFFFFE), repeating. The first word is accepted at t, and out_valid is high at t+2.
- Backpressure: c=20, out_ready toggled pseudo-randomly and in_valid gapped → no lost or duplicated index, out_data held while stalled, in_ready low while fill > BUF_W − IN_W.
- Start with cfg_c=0 and with cfg_c=21 → cfg_err=1, busy stays 0. A later valid start clears cfg_err.
- Reset asserted after 100 coefficients → all outputs 0 immediately and no done. A fresh start then produces index 0 first.
- With BIT_UNPACK_RANGE_CHECK_EN, signed b=2 and z=5 at index 7 → range_err rises with idx 7 (out_data −3) and stays set until the next start. Without the macro, range_err stays 0.

Source files
------------

// File: rtl/bit_unpack_stream_if.sv
// bit_unpack_stream_if
//   Handshake bundle for the streaming coefficient unpacker.
//   Input side : in_valid / in_ready / in_data  (packed byte stream, LSB-first)
//   Output side: out_valid / out_ready / out_data / out_idx / out_last
//   master : the side that feeds bytes and consumes coefficients
//   slave  : the unpacker itself
interface bit_unpack_stream_if #(
  parameter int IN_W   = 32,
  parameter int COEF_W = 24
);
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [COEF_W-1:0] out_data;
  logic [7:0]        out_idx;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/bit_unpack_stream.sv
// bit_unpack_stream
//   Streaming ML-DSA coefficient unpacker. Consumes a packed polynomial
//   (256 coefficients x c bits) as IN_W-bit words and emits one coefficient
//   per output handshake, either zero-extended (SimpleBitUnpack) or as
//   b - z modulo 2^COEF_W (BitUnpack).
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               begin a polynomial (honoured only when idle)
//   cfg_c/cfg_b/cfg_signed  width, bound, mode; latched on accepted start
//   bus (slave)         input word stream and output coefficient stream
//   busy                high while a polynomial is in flight
//   done                one-cycle pulse after the index-255 handshake
//   cfg_err             sticky, set by start with c == 0 or c > MAX_C
//   range_err           sticky out-of-range coefficient flag
// Optional feature macro: BIT_UNPACK_RANGE_CHECK_EN
//   defined   -> range_err flags z > b (unsigned) or z > 2b (signed)
//   undefined -> range_err tied low, no comparator
module bit_unpack_stream #(
  parameter int IN_W   = 32,
  parameter int MAX_C  = 20,
  parameter int COEF_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [4:0]         cfg_c,
  input  logic [COEF_W-1:0]  cfg_b,
  input  logic               cfg_signed,
  bit_unpack_stream_if.slave bus,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic               range_err
);
  localparam int BUF_W = MAX_C + IN_W;
  localparam int FW    = $clog2(BUF_W + 1);
  localparam int WLW   = 16;
  // 256*c/IN_W with IN_W a power of two is a left shift of c
  localparam int SH    = 8 - $clog2(IN_W);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic [BUF_W-1:0]  bit_buf;
  logic [FW-1:0]     fill;
  logic [WLW-1:0]    words_left;
  logic [7:0]        idx;
  logic [4:0]        c_q;
  logic [COEF_W-1:0] b_q;
  logic              sgn_q;

  logic              cfg_ok, acc, ext;
  logic [FW-1:0]     c_fw, fill_sh, fill_nx;
  logic [BUF_W-1:0]  buf_sh, buf_nx;
  logic [MAX_C-1:0]  mask, z;
  logic [COEF_W-1:0] z_ext, coef;

  assign cfg_ok = (cfg_c != 5'd0) && (32'(cfg_c) <= MAX_C);
  assign c_fw   = FW'(c_q);

  assign bus.in_ready = (state == RUN) && (words_left != '0) &&
                        (fill <= FW'(BUF_W - IN_W));
  assign acc = bus.in_valid && bus.in_ready;
  // Extract only into an empty or draining output register
  assign ext = (state == RUN) && (fill >= c_fw) &&
               (!bus.out_valid || bus.out_ready);

  assign mask  = ~({MAX_C{1'b1}} << c_q);
  assign z     = bit_buf[MAX_C-1:0] & mask;
  assign z_ext = {{(COEF_W-MAX_C){1'b0}}, z};
  assign coef  = sgn_q ? (b_q - z_ext) : z_ext;

  // Consume first, then append the new word right above the surviving bits
  assign buf_sh  = ext ? (bit_buf >> c_q) : bit_buf;
  assign fill_sh = ext ? (fill - c_fw) : fill;
  assign buf_nx  = acc ? (buf_sh | (BUF_W'(bus.in_data) << fill_sh)) : buf_sh;
  assign fill_nx = acc ? (fill_sh + FW'(IN_W)) : fill_sh;

`ifdef BIT_UNPACK_RANGE_CHECK_EN
  logic [COEF_W:0] lim;
  logic            z_bad;
  assign lim   = sgn_q ? {b_q, 1'b0} : {1'b0, b_q};
  assign z_bad = {1'b0, z_ext} > lim;
`else
  assign range_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bit_buf       <= '0;
      fill          <= '0;
      words_left    <= '0;
      idx           <= '0;
      c_q           <= '0;
      b_q           <= '0;
      sgn_q         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_err       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_idx   <= '0;
      bus.out_last  <= 1'b0;
`ifdef BIT_UNPACK_RANGE_CHECK_EN
      range_err     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state      <= RUN;
              busy       <= 1'b1;
              c_q        <= cfg_c;
              b_q        <= cfg_b;
              sgn_q      <= cfg_signed;
              words_left <= WLW'(cfg_c) << SH;
              bit_buf    <= '0;
              fill       <= '0;
              idx        <= '0;
              cfg_err    <= 1'b0;
`ifdef BIT_UNPACK_RANGE_CHECK_EN
              range_err  <= 1'b0;
`endif
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          bit_buf <= buf_nx;
          fill    <= fill_nx;
          if (acc) words_left <= words_left - WLW'(1);
          if (ext) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= coef;
            bus.out_idx   <= idx;
            bus.out_last  <= (idx == 8'd255);
            idx           <= idx + 8'd1;
`ifdef BIT_UNPACK_RANGE_CHECK_EN
            if (z_bad) range_err <= 1'b1;
`endif
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
          end
          if (bus.out_valid && bus.out_ready && bus.out_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bit_unpack_stream.sv
module tb_bit_unpack_stream;
  localparam int IN_W = 32, MAX_C = 20, COEF_W = 24;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              start, cfg_signed;
  logic [4:0]        cfg_c;
  logic [COEF_W-1:0] cfg_b;
  logic              busy, done, cfg_err, range_err;

  bit_unpack_stream_if #(.IN_W(IN_W), .COEF_W(COEF_W)) bus();

  bit_unpack_stream #(.IN_W(IN_W), .MAX_C(MAX_C), .COEF_W(COEF_W)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_c(cfg_c), .cfg_b(cfg_b),
    .cfg_signed(cfg_signed), .bus(bus), .busy(busy), .done(done),
    .cfg_err(cfg_err), .range_err(range_err)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [31:0]       zv[256];
  logic [23:0]       ev[256];
  logic [5119:0]     st;
  logic [23:0]       stbl[5];

  task automatic run_poly(input int c, input bit sg, input logic [23:0] b,
                          input bit rnd, input int abort_at, input int re_idx);
    int nw, acc, hs, cyc, first_acc, first_ov, fill_m;
    bit held;
    logic [23:0] hd;
    logic [7:0] hi;
    st = '0;
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < c; j++) st[i*c+j] = zv[i][j];
    nw = 256 * c / IN_W;
    @(negedge clk);
    start = 1'b1; cfg_c = 5'(c); cfg_b = b; cfg_signed = sg;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_cfg_err", 64'(cfg_err), 64'(0));
    chk("start_range_err", 64'(range_err), 64'(0));
    acc = 0; hs = 0; cyc = 0; first_acc = -1; first_ov = -1; held = 1'b0;
    hd = '0; hi = '0;
    while (1) begin
      if (cyc > 4000) begin
        chk("timeout", 64'(hs), 64'(256));
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        return;
      end
      if (first_ov < 0 && bus.out_valid) first_ov = cyc;
      if (held) begin
        chk("hold_valid", 64'(bus.out_valid), 64'(1));
        chk("hold_data", 64'(bus.out_data), 64'(hd));
        chk("hold_idx", 64'(bus.out_idx), 64'(hi));
      end
      if (abort_at > 0 && hs == abort_at) begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort_out_valid", 64'(bus.out_valid), 64'(0));
        chk("abort_out_data", 64'(bus.out_data), 64'(0));
        chk("abort_out_idx", 64'(bus.out_idx), 64'(0));
        chk("abort_out_last", 64'(bus.out_last), 64'(0));
        chk("abort_in_ready", 64'(bus.in_ready), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("abort_no_done", 64'(done), 64'(0));
          chk("abort_idle", 64'(busy), 64'(0));
        end
        return;
      end
      fill_m = IN_W*acc - c*(hs + (bus.out_valid ? 1 : 0));
      chk("in_ready", 64'(bus.in_ready), 64'((nw - acc) != 0 && fill_m <= MAX_C));
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (acc < nw && (!rnd || $urandom_range(0, 3) != 0)) begin
        bus.in_valid = 1'b1;
        bus.in_data  = st[acc*IN_W +: IN_W];
      end else begin
        bus.in_valid = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        acc++;
      end
      held = bus.out_valid && !bus.out_ready;
      hd = bus.out_data; hi = bus.out_idx;
      if (bus.out_valid && bus.out_ready) begin
        chk("idx", 64'(bus.out_idx), 64'(hs[7:0]));
        chk("data", 64'(bus.out_data), 64'(ev[hs]));
        chk("last", 64'(bus.out_last), 64'(hs == 255));
        chk("range_err", 64'(range_err), 64'(re_idx >= 0 && hs >= re_idx));
        hs++;
      end
      @(negedge clk);
      cyc++;
      if (hs == 256) break;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    chk("done_pulse", 64'(done), 64'(1));
    chk("done_busy", 64'(busy), 64'(0));
    chk("done_in_ready", 64'(bus.in_ready), 64'(0));
    chk("words_used", 64'(acc), 64'(nw));
    chk("latency", 64'(first_ov - first_acc), 64'(2));
    @(negedge clk);
    chk("done_drop", 64'(done), 64'(0));
    chk("range_sticky", 64'(range_err), 64'(re_idx >= 0));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_c = '0; cfg_b = '0; cfg_signed = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    stbl[0] = 24'd2; stbl[1] = 24'd1; stbl[2] = 24'd0;
    stbl[3] = 24'hFFFFFF; stbl[4] = 24'hFFFFFE;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_cfg_err", 64'(cfg_err), 64'(0));
    chk("rst_range_err", 64'(range_err), 64'(0));

    // bad widths: 0 and MAX_C+1
    start = 1'b1; cfg_c = 5'd0;
    @(negedge clk); start = 1'b0;
    chk("cfg0_err", 64'(cfg_err), 64'(1));
    chk("cfg0_busy", 64'(busy), 64'(0));
    start = 1'b1; cfg_c = 5'd21;
    @(negedge clk); start = 1'b0;
    chk("cfg21_err", 64'(cfg_err), 64'(1));
    chk("cfg21_busy", 64'(busy), 64'(0));

    // unsigned c=10, z = 3i mod 1024 (also clears cfg_err)
    for (int i = 0; i < 256; i++) begin zv[i] = 32'((i*3) % 1024); ev[i] = 24'((i*3) % 1024); end
    run_poly(10, 1'b0, 24'd0, 1'b0, 0, -1);

    // signed c=3 b=2, z = 0..4 repeating
    for (int i = 0; i < 256; i++) begin zv[i] = 32'(i % 5); ev[i] = stbl[i % 5]; end
    run_poly(3, 1'b1, 24'd2, 1'b0, 0, -1);

    // c=20 with gapped input and random backpressure
    for (int i = 0; i < 256; i++) begin
      zv[i] = 32'((i*40503 + 7) & 32'hFFFFF);
      ev[i] = 24'((i*40503 + 7) & 32'hFFFFF);
    end
    run_poly(20, 1'b0, 24'd0, 1'b1, 0, -1);

    // abort after 100 coefficients, then a clean run from index 0
    for (int i = 0; i < 256; i++) begin zv[i] = 32'((i*3) % 1024); ev[i] = 24'((i*3) % 1024); end
    run_poly(10, 1'b0, 24'd0, 1'b0, 100, -1);
    run_poly(10, 1'b0, 24'd0, 1'b0, 0, -1);

    // out-of-range z=5 at index 7 (signed b=2 -> -3)
    for (int i = 0; i < 256; i++) begin zv[i] = 32'(i % 5); ev[i] = stbl[i % 5]; end
    zv[7] = 32'd5; ev[7] = 24'hFFFFFD;
`ifdef BIT_UNPACK_RANGE_CHECK_EN
    run_poly(3, 1'b1, 24'd2, 1'b0, 0, 7);
`else
    run_poly(3, 1'b1, 24'd2, 1'b0, 0, -1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
